// File: rtl/ahbl_master_bridge_if.sv
// rtl/ahbl_master_bridge_if.sv - AHB-Lite single-master bus bundle between the bridge initiator and its slaves
interface ahbl_master_bridge_if #(
   parameter int AHB_AWIDTH = 32,
   parameter int AHB_DWIDTH = 32
);
   logic [AHB_AWIDTH-1:0] HADDR;
   logic [1:0]            HTRANS;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic [2:0]            HBURST;
   logic [3:0]            HPROT;
   logic [AHB_DWIDTH-1:0] HWDATA;
   logic [AHB_DWIDTH-1:0] HRDATA;
   logic                  HREADY;
   logic [1:0]            HRESP;

   modport master (
      output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/ahbl_master_bridge.sv
// rtl/ahbl_master_bridge.sv - command-port to AHB-Lite initiator; AHBL_MST_INCR_EN enables INCR bursts and the 1 KB check
module ahbl_master_bridge #(
   parameter int AHB_AWIDTH = 32,
   parameter int AHB_DWIDTH = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESETN,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [AHB_AWIDTH-1:0] cmd_addr,
   input  logic [2:0]            cmd_size,
   input  logic [3:0]            cmd_len,
   input  logic [AHB_DWIDTH-1:0] wr_data,
   output logic                  wr_take,
   output logic [AHB_DWIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  done,
   output logic                  err,
   ahbl_master_bridge_if.master  bus
);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;
   localparam logic [2:0] BU_SINGLE = 3'b000;
   localparam logic [2:0] BU_INCR   = 3'b001;

   typedef enum logic [2:0] {S_IDLE, S_REJ, S_ADDR, S_DATA, S_ERR, S_FIN} state_t;

   state_t                state, state_nxt;
   logic [3:0]            beats_m1;
   logic [3:0]            addr_left;
   logic [3:0]            data_left;
   logic                  err_q;
   logic                  misaligned;
   logic                  cross_1k;
   logic                  cmd_bad;
   logic                  addr_step;
   logic [AHB_AWIDTH-1:0] addr_inc;
   logic                  unused_bits;

   assign bus.HPROT   = 4'b0011;
   assign addr_inc    = AHB_AWIDTH'(1) << bus.HSIZE;
   assign unused_bits = ^{cmd_len, bus.HRESP[1]};

`ifdef AHBL_MST_INCR_EN
   logic [10:0] span;
   logic [10:0] last_byte;

   assign beats_m1 = cmd_len;

   // Last byte of the burst within its 1 KB page; bit 10 set means the burst leaves the page
   always_comb begin
      span      = (11'(cmd_len) + 11'd1) << cmd_size[1:0];
      last_byte = {1'b0, cmd_addr[9:0]} + span - 11'd1;
      cross_1k  = last_byte[10];
   end
`else
   assign beats_m1 = 4'd0;
   assign cross_1k = 1'b0;
`endif

   // Alignment of the start address to the transfer size
   always_comb begin
      misaligned = 1'b0;
      case (cmd_size)
         3'd1:    misaligned = cmd_addr[0];
         3'd2:    misaligned = |cmd_addr[1:0];
         default: misaligned = 1'b0;
      endcase
   end

   assign cmd_bad = (cmd_size > 3'd2) | misaligned | cross_1k;

   // An address phase on the bus is accepted: ADDR with HREADY, or a clean beat completion in DATA
   assign addr_step = bus.HREADY &
                      ((state == S_ADDR) | ((state == S_DATA) & ~bus.HRESP[0]));

   // State register
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next state plus the command-side handshake outputs
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      wr_take   = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = cmd_bad ? S_REJ : S_ADDR;
         end
         S_REJ: begin
            done      = 1'b1;
            err       = 1'b1;
            state_nxt = S_IDLE;
         end
         S_ADDR: begin
            if (bus.HREADY) begin
               wr_take   = bus.HWRITE;
               state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (bus.HRESP[0]) begin
               state_nxt = bus.HREADY ? S_FIN : S_ERR;
            end else if (bus.HREADY) begin
               // Next beat's data is taken only when its SEQ address phase completes
               wr_take = bus.HWRITE & (bus.HTRANS == TR_SEQ);
               if (data_left == 4'd0) state_nxt = S_FIN;
            end
         end
         S_ERR: begin
            if (bus.HREADY) state_nxt = S_FIN;
         end
         S_FIN: begin
            done      = 1'b1;
            err       = err_q;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Registered bus drive, beat counters, read capture and error flag
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         bus.HADDR  <= '0;
         bus.HTRANS <= TR_IDLE;
         bus.HWRITE <= 1'b0;
         bus.HSIZE  <= 3'd0;
         bus.HBURST <= BU_SINGLE;
         bus.HWDATA <= '0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         err_q      <= 1'b0;
         addr_left  <= 4'd0;
         data_left  <= 4'd0;
      end else begin
         rd_valid <= 1'b0;
         if (wr_take) bus.HWDATA <= wr_data;

         if (addr_step) begin
            if (addr_left != 4'd0) begin
               bus.HADDR  <= bus.HADDR + addr_inc;
               bus.HTRANS <= TR_SEQ;
               addr_left  <= addr_left - 4'd1;
            end else begin
               bus.HTRANS <= TR_IDLE;
            end
         end

         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  err_q <= 1'b0;
                  if (!cmd_bad) begin
                     bus.HADDR  <= cmd_addr;
                     bus.HTRANS <= TR_NONSEQ;
                     bus.HWRITE <= cmd_write;
                     bus.HSIZE  <= cmd_size;
                     bus.HBURST <= (beats_m1 == 4'd0) ? BU_SINGLE : BU_INCR;
                     addr_left  <= beats_m1;
                     data_left  <= beats_m1;
                  end
               end
            end
            S_DATA: begin
               if (bus.HRESP[0]) begin
                  // Cancel whatever remains of the burst
                  bus.HTRANS <= TR_IDLE;
                  err_q      <= 1'b1;
               end else if (bus.HREADY) begin
                  if (!bus.HWRITE) begin
                     rd_data  <= bus.HRDATA;
                     rd_valid <= 1'b1;
                  end
                  if (data_left != 4'd0) data_left <= data_left - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/ahbl_master_bridge.md
# ahbl_master_bridge

AHB-Lite initiator that turns simple command-port requests from the bridge/bootloader control logic into AHB-Lite transfers on a single-master layer. It is the counterpart of the AHB-Lite SRAM responder and drives the same bus toward it and toward other slaves. It handles pipelined address/data phases, slave wait states and the two-cycle ERROR response, and returns read data and completion status to the command side.

## Interface
- AHB_AWIDTH, 32, address width; fixed at 32.
- AHB_DWIDTH, 32, data width; fixed at 32.
- HCLK  input  1  sole clock; all logic is on the rising edge.
- HRESETN  input  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high in IDLE only; the command is accepted when cmd_valid & cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  32  start byte address.
- cmd_size  input  3  HSIZE encoding; only 0, 1 and 2 are legal.
- cmd_len  input  4  number of beats minus 1; used only with AHBL_MST_INCR_EN.
- wr_data  input  32  write beat data; must be valid when wr_take is high.
- wr_take  output  1  one-cycle pulse when wr_data is captured for the current beat.
- rd_data  output  32  registered read beat.
- rd_valid  output  1  one-cycle pulse per read beat.
- done  output  1  one-cycle pulse at command completion.
- err  output  1  valid with done; 1 = error response, or command rejected.
- HADDR  output  32; HTRANS  output  2; HWRITE  output  1; HSIZE  output  3; HBURST  output  3.
- HPROT  output  4  constant 4'b0011.
- HWDATA  output  32.
- HRDATA  input  32; HREADY  input  1; HRESP  input  2 (bit 0 = ERROR).

## Operation
- FSM states and transitions:
  - IDLE: cmd_ready=1.
    - On accept, the block latches the command fields.
    - If cmd_size>2, the address is unaligned to 1<<cmd_size, or the burst crosses a 1 KB boundary, it goes to REJ.
    - Otherwise it goes to ADDR.
  - REJ: pulses done=1 and err=1 for one cycle, issues no bus transfer, then returns to IDLE.
  - ADDR: first address phase.
    - Drives HTRANS=NONSEQ(2'b10), and HBURST=SINGLE(000) when the beat count is 1, else INCR(001).
    - For writes, pulses wr_take in this cycle and registers wr_data.
    - When HREADY=1, goes to DATA.
  - DATA: data phase of the current beat, overlapped with the address phase of the next beat (HTRANS=SEQ, HADDR += 1<<cmd_size) while beats remain; otherwise HTRANS=IDLE.
    - HWDATA holds the registered write beat.
    - When HREADY=1 and HRESP[0]=0, the beat completes.
      - For a read, HRDATA is captured into rd_data and rd_valid pulses next cycle.
      - For a write, wr_take pulses with the next address phase.
    - After the last beat completes, goes to FIN.
    - When HRESP[0]=1 and HREADY=0, goes to ERR.
  - ERR: first cycle of the ERROR response already seen.
    - Forces HTRANS=IDLE for the rest of the burst (cancelled).
    - Waits for HREADY=1, then goes to FIN with err set.
  - FIN: pulses done for one cycle, with err, then returns to IDLE.
- Every beat (including the first) gets exactly one wr_take pulse; the source presents each beat's data when wr_take is high. There is no wr_take after an error.
- Address increments wrap within 32 bits; the 1 KB check guarantees no carry across bit 10.

## Timing
- Reset values:
  - cmd_ready=1, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0.
  - rd_data=0, rd_valid=0, wr_take=0, done=0, err=0.
  - FSM=IDLE.
- All AHB outputs are registered. The bus is driven only from ADDR/DATA; IDLE drives HTRANS=IDLE.
- Zero-wait single read, latency cycle by cycle:
  - Cycle 0: accept.
  - Cycle 1: address phase.
  - Cycle 2: data phase, HREADY=1.
  - Cycle 3: rd_valid and done.
  - cmd_ready returns in cycle 4.
- Zero-wait N-beat burst: done occurs N+2 cycles after accept.
- Wait states stretch the current phase; HADDR, HTRANS, HWDATA and HBURST hold while HREADY=0.
- ERROR response: HTRANS=IDLE in the cycle after the first ERROR cycle is observed, and done/err one cycle after the second ERROR cycle.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronously); no done is issued for the aborted command.

## Configuration
- AHBL_MST_INCR_EN:
  - Defined: cmd_len sets 1–16 beats, INCR bursts are issued, and the 1 KB boundary check is active.
  - Undefined: cmd_len is ignored, every command is one SINGLE beat, HBURST is always 000, and the 1 KB check logic is removed.

## Test plan
- Single write:
  - Stimulus: addr 0x100, size 2, data 0xDEADBEEF, zero wait.
  - Required response: HTRANS=NONSEQ with HADDR=0x100 in one cycle; the next cycle has HWDATA=0xDEADBEEF; done=1, err=0 three cycles after accept.
- Single read with 3 wait states:
  - Stimulus: HRDATA=0x12345678.
  - Required response: rd_data=0x12345678 with rd_valid and done, 6 cycles after accept; HADDR is held throughout the waits.
- INCR burst (macro on):
  - Stimulus: len 3, size 2, addr 0x3F0.
  - Required response: HADDR sequence 0x3F0/0x3F4/0x3F8/0x3FC; NONSEQ then SEQ×3; 4 wr_take pulses.
- 1 KB crossing / illegal commands (macro on):
  - Stimulus: addr 0x3F8, len 3; then size 3; then addr 0x102 with size 2.
  - Required response: each gives done=1, err=1 one cycle after accept, with no HTRANS activity.
- Error mid-burst:
  - Stimulus: HRESP ERROR on beat 2 of 4.
  - Required response: HTRANS=IDLE the next cycle; no further beats; done=1 and err=1; 1 rd_valid for reads.
- Reset during a wait state:
  - Stimulus: assert HRESETN low during a wait state.
  - Required response: HTRANS=IDLE and cmd_ready=1 immediately, with no done pulse.
